// File: rtl/rgb2ycbcr_ctrl.sv
// rgb2ycbcr_ctrl: flow-control sequencer around the fixed-latency, non-stalling rgb2ycbcr pipeline.
//   - Accepts a valid/ready RGB stream and issues pixels into the pipeline against credits.
//   - Captures pipeline results into an output FIFO that credits keep from overflowing.
//   - Presents results as a valid/ready stream tagged with block-end and frame-end markers.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/s_data   input pixel stream, {B,G,R}
//   cc_enable/cc_data        issue strobe and pixel into rgb2ycbcr
//   cc_enable_out/cc_data_out result strobe and pixel {Cr,Cb,Y} from rgb2ycbcr
//   m_valid/m_ready/m_data   output pixel stream, {Cr,Cb,Y}
//   m_last_block/m_last_frame markers on the last pixel of a block / frame
//   err                      sticky protocol error, cleared only by rst
//
// Optional build macro RGB2YCBCR_CTRL_LATCHK_EN: tracks issues in a LAT-deep shift register,
// flags any cc_enable_out that disagrees with it, and captures on the tracked strobe instead.
module rgb2ycbcr_ctrl #(
  parameter int unsigned LAT          = 3,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BLOCK_PIXELS = 64,
  parameter int unsigned FRAME_PIXELS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  output logic        cc_enable,
  output logic [23:0] cc_data,
  input  logic [23:0] cc_data_out,
  input  logic        cc_enable_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        m_last_block,
  output logic        m_last_frame,
  output logic        err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned FlW  = $clog2(LAT + 1);
  localparam int unsigned PixW = $clog2(BLOCK_PIXELS);
  localparam int unsigned FrmW = $clog2(FRAME_PIXELS);

  logic [FlW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [23:0]     mem_q [FIFO_DEPTH];
  logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
  logic [FrmW-1:0] frm_cnt_q, frm_cnt_d;
  logic            err_q, err_d;

  logic            flush;
  logic            issue;
  logic            pop;
  logic            full;
  logic [CntW-1:0] inflight;
  logic            cap_en;
  logic            cap_bad;
  logic            wr;
  logic            lat_err;

  // Flush runs for LAT cycles after reset release so stale pipeline results are dropped.
  assign flush = (flush_cnt_q != FlW'(LAT));

  // Decoded from registers only: no path from m_ready to s_ready.
  assign s_ready   = !flush && (outst_q < CntW'(FIFO_DEPTH));
  assign issue     = s_valid && s_ready;
  assign cc_enable = issue;
  assign cc_data   = s_data;

  assign m_valid      = (count_q != '0);
  assign m_data       = mem_q[rd_ptr_q];
  assign pop          = m_valid && m_ready;
  assign m_last_block = m_valid && (pix_cnt_q == PixW'(BLOCK_PIXELS - 1));
  assign m_last_frame = m_valid && (frm_cnt_q == FrmW'(FRAME_PIXELS - 1));
  assign err          = err_q;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  // Pixels issued but not yet captured; zero means any result strobe is unexpected.
  assign inflight = outst_q - count_q;

`ifdef RGB2YCBCR_CTRL_LATCHK_EN
  logic [LAT-1:0] lat_sr_q, lat_sr_d;

  assign lat_sr_d = (lat_sr_q << 1) | LAT'(issue);
  assign cap_en   = lat_sr_q[LAT-1];
  assign lat_err  = !flush && (cc_enable_out != cap_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_sr_q <= '0;
    end else begin
      lat_sr_q <= lat_sr_d;
    end
  end
`else
  assign cap_en  = cc_enable_out;
  assign lat_err = 1'b0;
`endif

  assign cap_bad = cap_en && !flush && (full || (inflight == '0));
  assign wr      = cap_en && !flush && !cap_bad;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      flush_cnt_d = flush_cnt_q + FlW'(1);
    end

    case ({issue, pop})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    case ({wr, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Depth is a power of two, so pointers wrap naturally.
    wr_ptr_d = wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    pix_cnt_d = pix_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (pop) begin
      pix_cnt_d = (pix_cnt_q == PixW'(BLOCK_PIXELS - 1)) ? '0 : pix_cnt_q + PixW'(1);
      frm_cnt_d = (frm_cnt_q == FrmW'(FRAME_PIXELS - 1)) ? '0 : frm_cnt_q + FrmW'(1);
    end

    err_d = err_q || cap_bad || lat_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_cnt_q   <= '0;
      frm_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_cnt_q   <= pix_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      err_q       <= err_d;
    end
  end

  // Storage is cleared on reset so m_data reads 0 while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[wr_ptr_q] <= cc_data_out;
    end
  end

endmodule

// File: doc/rgb2ycbcr_ctrl.md
Name: rgb2ycbcr_ctrl

Overview:
Flow-control sequencer for the `rgb2ycbcr` colour-conversion pipeline. The pipeline has a fixed latency and cannot stall, so this block supplies the backpressure around it.
- Accepts a valid/ready RGB pixel stream and issues pixels into the pipeline using credits.
- Buffers the YCbCr results in an internal FIFO.
- Presents the results downstream as a valid/ready stream, tagged with 8x8-block-end and frame-end markers for the DCT stage.

Parameters:
LAT, 3, pipeline latency of rgb2ycbcr in cycles (cc_enable to cc_enable_out)
FIFO_DEPTH, 8, output FIFO entries; must be >= LAT+1, power of two
BLOCK_PIXELS, 64, pixels per block (8x8)
FRAME_PIXELS, 4096, pixels per frame; multiple of BLOCK_PIXELS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&s_ready
s_data  in  24  input pixel {B,G,R}, R in [7:0]
cc_enable  out  1  issue strobe to rgb2ycbcr.enable
cc_data  out  24  pixel to rgb2ycbcr.data_in
cc_data_out  in  24  rgb2ycbcr.data_out {Cr,Cb,Y}, Y in [7:0]
cc_enable_out  in  1  rgb2ycbcr.enable_out
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  24  {Cr,Cb,Y}
m_last_block  out  1  m_data is the last pixel of a block
m_last_frame  out  1  m_data is the last pixel of the frame
err  out  1  sticky protocol error

Behaviour:
Reset values:
- All outputs are 0 during reset, including s_ready, m_valid and err.
- FIFO is empty; all counters are 0.

Post-reset flush:
- After rst deasserts, a flush counter runs for LAT cycles.
- During the flush, s_ready=0 and any cc_enable_out pulse is discarded. This drops stale pipeline data.

Credits:
- outstanding = pixels issued but not yet popped (in-flight plus FIFO occupancy); width $clog2(FIFO_DEPTH+1).
- s_ready = !flush && (outstanding < FIFO_DEPTH). s_ready is decoded from registers only, with no combinational path from m_ready.
- Issue: cc_enable = s_valid & s_ready and cc_data = s_data, both combinational. Each issue does outstanding+1.
- Pop: m_valid & m_ready does outstanding-1.
- A simultaneous issue and pop leaves outstanding unchanged.

Capture:
- On cc_enable_out=1, cc_data_out is written to the FIFO tail.
- The FIFO can never be full at capture, because credits guarantee space.
- Capture on a full FIFO sets err and drops the data.

Output:
- m_valid = !empty. m_data is the FIFO head and is registered (no bubble on back-to-back pops).
- First-word latency: a pixel issued at cycle t is captured at t+LAT and m_valid is high at t+LAT+1.
- Sustained throughput is 1 pixel/clk while m_ready=1.
- m_data, m_last_block and m_last_frame hold stable while m_valid & !m_ready.

Counters (advance on pop only):
- pix_cnt runs 0..BLOCK_PIXELS-1 and wraps to 0.
- frm_cnt runs 0..FRAME_PIXELS-1 and wraps to 0.
- m_last_block = m_valid && pix_cnt==BLOCK_PIXELS-1.
- m_last_frame = m_valid && frm_cnt==FRAME_PIXELS-1.
- m_last_frame implies m_last_block.

Error:
- cc_enable_out with outstanding minus FIFO occupancy == 0 (an unexpected result) sets err.
- err clears only on rst.

Reset mid-operation:
- The FIFO and counters clear immediately (asynchronous).
- In-flight pixels are lost and are absorbed by the post-reset flush.

Optional Feature:
Macro: RGB2YCBCR_CTRL_LATCHK_EN.
- Defined: a LAT-deep shift register records cc_enable.
  - cc_enable_out must equal the shift-register output every cycle, excluding the flush window.
  - A mismatch sets err.
  - The capture enable becomes the shift-register output, so it tolerates glitching cc_enable_out; cc_data_out is still the data source.
- Not defined: no shift register; capture uses cc_enable_out directly; err is produced by the full/unexpected checks only.

Test Plan:
- Reset, then hold s_valid=1 from the first cycle: s_ready=0 for exactly 3 cycles after rst falls; the first cc_enable is in cycle 4.
- Input black, white, gray(128), one per cycle, with m_ready=1: m_data Y/Cb/Cr = 0/128/128, 255/128/128, 128/128/128. The first m_valid is 4 cycles after the first issue; the three outputs are consecutive.
- Stream with m_ready=0: exactly 8 issues, then s_ready=0 and m_valid stays 1 with m_data stable. Raise m_ready: 1 pop and 1 issue per cycle; no data lost or reordered, checked by a scoreboard against 100 random pixels.
- Stream 4096 pixels with random m_ready at 50%: m_last_block is high on pops 63, 127, … 4095 (64 pulses); m_last_frame is high only on pop 4095; pop 4096 has both flags 0.
- Pulse cc_enable_out with nothing issued: err=1 and stays 1 until rst; no FIFO write.
- Assert rst with 5 pixels in flight or buffered: m_valid=0 immediately; after release, the stale cc_enable_out pulses are ignored, err=0, and the FIFO stays empty.
